// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between IF and data ports.
// One transaction in flight; data has priority with bounded IF starvation.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam logic [3:0] S_MAX  = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          starve_q, starve_d;
  logic [3:0]          wait_q, wait_d;
  logic                discard_q, discard_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic if_elig;
  logic starve_hit;
  logic flush_hit;

  assign if_elig    = if_req & ~if_flush;
  assign starve_hit = if_elig & (starve_q == S_MAX);
  assign flush_hit  = if_flush & ~owner_q;

  // next-state, grant, latch and capture logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    wait_d     = wait_q;
    discard_d  = discard_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (starve_hit || (if_elig && !d_req)) begin
          owner_d  = 1'b0;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = S_ISSUE;
        end else if (d_req) begin
          owner_d = 1'b1;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          state_d = S_ISSUE;
          if (if_elig) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
          end else if (!if_req) begin
            starve_d = '0;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = LAT_M1;
        state_d = S_WAIT;
        if (flush_hit) discard_d = 1'b1;
      end
      S_WAIT: begin
        if (flush_hit) discard_d = 1'b1;
        if (wait_q == '0) begin
          state_d = S_RESP;
          if (owner_q) begin
            d_rdata_d = we_q ? '0 : mem_rdata;
          end else if (!(discard_q || flush_hit)) begin
            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and datapath registers, async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_q   <= '0;
      wait_q     <= '0;
      discard_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      wait_q     <= wait_d;
      discard_q  <= discard_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_valid  = (state_q == S_RESP) & ~owner_q & ~discard_q;
  assign d_valid   = (state_q == S_RESP) & owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_valid;
  assign d_stall   = d_req & ~d_valid;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random two-port traffic against a transaction model.
// Scoreboard queues hold expected issues and completions per port.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int SMX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
  } iss_t;
  typedef struct {
    int          c;
    logic [31:0] d;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t ifq[$];
  rsp_t dq[$];

  int ncheck = 0;
  int nerr   = 0;
  int cyc    = 0;
  bit mon_en = 0;

  bit gen_en, flush_en;
  int p_if, p_d;
  bit ifv_evt, dv_evt;
  bit exp_ifv, exp_dv, exp_busy;

  bit          act;
  int          g, free_c, starve;
  bit          towner, tdisc, twe;
  logic [31:0] taddr;

  function automatic logic [31:0] hsh(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h8C01_0004;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act_v,
                     input logic [63:0] exp_v);
    ncheck++;
    if (act_v !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act_v, exp_v, cyc);
    end
  endtask

  task automatic flag(input string nm);
    ncheck++;
    nerr++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // one cycle: agents, memory model, transaction-level reference
  task automatic step();
    bit ie;
    @(posedge clk);
    #1;
    cyc++;
    if (ifv_evt) begin
      if (gen_en && $urandom_range(0, 99) < p_if) if_addr = rnd_addr();
      else if_req = 1'b0;
    end
    if (dv_evt) begin
      if (gen_en && $urandom_range(0, 99) < p_d) begin
        d_addr  = rnd_addr();
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end else d_req = 1'b0;
    end
    ifv_evt = 0;
    dv_evt  = 0;
    if (!if_req && gen_en && $urandom_range(0, 99) < p_if) begin
      if_req  = 1'b1;
      if_addr = rnd_addr();
    end
    if (!d_req && gen_en && $urandom_range(0, 99) < p_d) begin
      d_req   = 1'b1;
      d_addr  = rnd_addr();
      d_we    = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
    end
    if_flush = gen_en && flush_en && ($urandom_range(0, 11) == 0);
    if (if_flush) begin
      if_req  = 1'b1;
      if_addr = rnd_addr();
    end
    exp_ifv = 0;
    exp_dv  = 0;
    if (act) begin
      if (!towner && if_flush && cyc >= g + 1 && cyc <= g + 1 + LAT)
        tdisc = 1;
      if (cyc == g + 2 + LAT) begin
        if (towner) begin
          dq.push_back('{cyc, twe ? 32'h0 : hsh(taddr)});
          exp_dv = 1;
          dv_evt = 1;
        end else if (!tdisc) begin
          ifq.push_back('{cyc, hsh(taddr)});
          exp_ifv = 1;
          ifv_evt = 1;
        end
      end
    end
    exp_busy  = act && cyc >= g + 1 && cyc <= g + 2 + LAT;
    mem_rdata = (act && cyc == g + 1 + LAT) ? hsh(taddr) : $urandom;
    if (cyc >= free_c) begin
      act = 0;
      ie  = if_req && !if_flush;
      if ((ie && starve == SMX) || (ie && !d_req)) begin
        act = 1; towner = 0; taddr = if_addr; twe = 0;
        starve = 0;
        iss_q.push_back('{cyc + 1, if_addr, 1'b0, 32'h0});
      end else if (d_req) begin
        act = 1; towner = 1; taddr = d_addr; twe = d_we;
        if (ie) starve = (starve < 15) ? starve + 1 : 15;
        else if (!if_req) starve = 0;
        iss_q.push_back('{cyc + 1, d_addr, d_we, d_wdata});
      end
      if (act) begin
        g      = cyc;
        free_c = cyc + 3 + LAT;
        tdisc  = 0;
      end
    end
  endtask

  // monitor: pops expectations whenever the DUT presents an event
  initial begin
    iss_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", busy, exp_busy);
        chk("if_stall", if_stall, if_req & ~exp_ifv);
        chk("d_stall", d_stall, d_req & ~exp_dv);
        if (mem_req) begin
          if (iss_q.size() == 0) flag("mem_req_unexpected");
          else begin
            e = iss_q.pop_front();
            chk("issue_cycle", cyc, e.c);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", mem_we, e.we);
            chk("mem_wdata", mem_wdata, e.wd);
          end
        end else if (iss_q.size() > 0 && iss_q[0].c <= cyc) begin
          flag("mem_req_missing");
          void'(iss_q.pop_front());
        end
        if (if_valid) begin
          if (ifq.size() == 0) flag("if_valid_unexpected");
          else begin
            r = ifq.pop_front();
            chk("if_cycle", cyc, r.c);
            chk("if_rdata", if_rdata, r.d);
          end
        end else if (ifq.size() > 0 && ifq[0].c <= cyc) begin
          flag("if_valid_missing");
          void'(ifq.pop_front());
        end
        if (d_valid) begin
          if (dq.size() == 0) flag("d_valid_unexpected");
          else begin
            r = dq.pop_front();
            chk("d_cycle", cyc, r.c);
            chk("d_rdata", d_rdata, r.d);
          end
        end else if (dq.size() > 0 && dq[0].c <= cyc) begin
          flag("d_valid_missing");
          void'(dq.pop_front());
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_valid"}, if_valid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_valid"}, d_valid, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    if_req = 0; if_flush = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0;
    gen_en = 0; flush_en = 0; p_if = 0; p_d = 0;
    ifv_evt = 0; dv_evt = 0; exp_ifv = 0; exp_dv = 0; exp_busy = 0;
    act = 0; g = 0; free_c = 0; starve = 0;
    towner = 0; tdisc = 0; twe = 0; taddr = 0;
    #3;
    chk_zero("reset");
    chk("reset_if_stall", if_stall, 0);
    chk("reset_d_stall", d_stall, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1;

    gen_en = 1; flush_en = 1; p_if = 40; p_d = 40;
    repeat (2000) step();
    flush_en = 0; p_if = 100; p_d = 100;
    repeat (300) step();
    flush_en = 1; p_if = 100; p_d = 70;
    repeat (500) step();
    gen_en = 0; flush_en = 0;
    repeat (80) step();
    chk("scoreboard_drain", iss_q.size() + ifq.size() + dq.size(), 0);
    mon_en = 0;

    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h40; if_flush = 0;
    @(posedge clk); #1;
    chk("rst_test_mem_req", mem_req, 1);
    chk("rst_test_mem_addr", mem_addr, 32'h40);
    @(posedge clk); #1;
    chk("rst_test_busy_wait", busy, 1);
    rst = 1'b0;
    #1;
    chk_zero("midwait_rst");
    chk("midwait_rst_if_stall", if_stall, 1);
    if_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", if_valid | d_valid, 0);
      chk("post_rst_idle", busy, 0);
    end
    if_req = 1; if_addr = 32'h80;
    @(posedge clk); #1;
    chk("fresh_mem_req", mem_req, 1);
    chk("fresh_mem_addr", mem_addr, 32'h80);
    @(posedge clk); #1;
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_rdata = hsh(32'h80);
    chk("fresh_not_early", if_valid, 0);
    @(posedge clk); #1;
    mem_rdata = $urandom;
    chk("fresh_if_valid", if_valid, 1);
    chk("fresh_if_rdata", if_rdata, hsh(32'h80));
    chk("fresh_if_stall", if_stall, 0);
    if_req = 0;
    @(posedge clk); #1;
    chk("fresh_idle", busy, 0);
    chk("fresh_valid_one_cycle", if_valid, 0);
    chk("fresh_rdata_hold", if_rdata, hsh(32'h80));

    $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction fetch (IF) port and data (MEM-stage) port.
- Arbitrates, sequences one outstanding memory transaction at a time, and returns read data or write acknowledge to the winner.
- Generates per-port stall signals for the pipeline registers.
- Supports cancelling an in-flight fetch on branch/jump flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the mem_req cycle to the mem_rdata-valid cycle; legal range 1..15.
- STARVE_MAX, 2, consecutive data-port wins allowed while IF waits; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset.
- if_req  input  1  fetch request, held until if_valid.
- if_addr  input  ADDR_W  fetch address.
- if_flush  input  1  cancel pending/in-flight fetch.
- if_valid  output  1  one-cycle fetch completion.
- if_rdata  output  DATA_W  fetched instruction.
- if_stall  output  1  if_req & ~if_valid.
- d_req  input  1  data request, held until d_valid.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_valid  output  1  one-cycle data completion.
- d_rdata  output  DATA_W  load data; 0 for stores.
- d_stall  output  1  d_req & ~d_valid.
- mem_req  output  1  one-cycle issue strobe.
- mem_we  output  1  write enable, valid with mem_req.
- mem_addr  output  ADDR_W  latched address.
- mem_wdata  output  DATA_W  latched store data.
- mem_rdata  input  DATA_W  valid MEM_LAT cycles after the mem_req cycle.
- busy  output  1  state != IDLE.

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; starve_cnt, wait_cnt, owner and discard flag clear.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, d_valid, d_rdata, busy.
  - if_stall/d_stall follow their equations.
  - An in-flight transaction is dropped; no valid is ever produced for it.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All transitions occur on rising clk.
- IDLE, arbitration on requests sampled this cycle:
  - Data request present and no starvation condition: data wins.
  - Starvation condition (if_req & ~if_flush & starve_cnt == STARVE_MAX): IF wins.
  - Only one eligible request: that request wins.
  - if_flush=1 makes if_req ineligible this cycle.
  - On a win: latch owner, address, we (0 for IF) and wdata (0 for IF); go to ISSUE.
  - No eligible request: stay in IDLE.
- starve_cnt update, at each IDLE grant:
  - Data wins while if_req & ~if_flush: +1, saturating.
  - IF wins, or if_req low: cleared to 0.
- ISSUE (1 cycle): mem_req=1; mem_we/mem_addr/mem_wdata driven from the latches. Load wait_cnt=MEM_LAT-1; go to WAIT.
- mem_* hold latched values outside ISSUE; mem_req is 0 outside ISSUE.
- WAIT (MEM_LAT cycles): decrement wait_cnt. At wait_cnt==0, capture mem_rdata (0 if store) into the owner's rdata register; go to RESP.
- RESP (1 cycle): owner's valid=1 with rdata stable; go to IDLE.
  - rdata holds until the next completion for that port.
  - Requester must drop or replace its request on the edge closing RESP; a request seen in the following IDLE is new.
- Latency: req seen at cycle 0 -> mem_req cycle 1 -> mem_rdata cycle 1+MEM_LAT -> valid cycle 2+MEM_LAT. Next grant evaluated at cycle 3+MEM_LAT.
- Flush:
  - if_flush=1 in any ISSUE/WAIT cycle of an IF-owned transaction sets the discard flag.
  - With discard set: the memory access completes, rdata is not updated, if_valid stays 0, and RESP still spends its cycle.
  - if_flush during RESP does not suppress that if_valid.
  - if_flush never affects data-owned transactions.
  - Discard flag clears on IDLE.
- Requests arriving while busy wait; they are never lost while held.

Test Plan (MEM_LAT=2, STARVE_MAX=2):
1. Single fetch: if_req=1, if_addr=0x40 at cycle 0 -> mem_req=1, mem_addr=0x40, mem_we=0 at cycle 1; mem_rdata=0x8C010004 at cycle 3 -> if_valid=1, if_rdata=0x8C010004 at cycle 4 only; if_stall=1 cycles 0-3; busy 0 at cycle 5.
2. Starvation: if_req and d_req held continuously (each re-asserted with a new address after valid) -> grant order D, D, I, D, D, I; mem_req every 5 cycles.
3. Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1 with that addr/data in the ISSUE cycle; d_valid at cycle 4 with d_rdata=0.
4. Flush: fetch 0x40 issued, if_flush=1 at cycle 2 -> no if_valid at cycle 4; if_rdata keeps its old value; IDLE at cycle 5; new if_req 0x80 gives mem_req at cycle 6.
5. Flush in IDLE with both requests: if_flush=1, if_req=1, d_req=1 at cycle 0 -> data granted; starve_cnt unchanged at 0.
6. Reset mid-WAIT: rst low at cycle 2 -> all outputs 0 immediately, busy=0; after release, no valid for the old access; a fresh if_req completes after 4 cycles.
